// File: rtl/mmss_pkg.sv
// Shared constants for the mm:ss stopwatch: FSM encoding and BCD digit limits.
// Latency: none (declarations only).
// Backpressure: none.
package mmss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

endpackage

// File: rtl/mmss_stopwatch_if.sv
// Control inputs and BCD display outputs of the stopwatch.
// Latency: none (wiring only).
// Backpressure: none; TICK is a fire-and-forget pulse.
interface mmss_stopwatch_if;
    logic       TICK;
    logic       START;
    logic       CLR_TIME;
    logic [3:0] SEC_ONES;
    logic [3:0] SEC_TENS;
    logic [3:0] MIN_ONES;
    logic [3:0] MIN_TENS;
    logic       RUNNING;
    logic       ROLLOVER;

    modport master (
        output TICK, START, CLR_TIME,
        input  SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS, RUNNING, ROLLOVER
    );

    modport slave (
        input  TICK, START, CLR_TIME,
        output SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS, RUNNING, ROLLOVER
    );
endinterface

// File: rtl/bcd_digit.sv
// One BCD counter digit 0..MAX with carry-out on the enabled terminal count.
// Latency: Q updates one clock after EN; CARRY is combinational.
// Backpressure: none.
module bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       CLR,
    input  logic       EN,
    output logic [3:0] Q,
    output logic       CARRY
);

    always_ff @(posedge CLOCK) begin
        if (RESET || CLR) begin
            Q <= 4'd0;
        end else if (EN) begin
            Q <= (Q == MAX) ? 4'd0 : Q + 4'd1;
        end
    end

    assign CARRY = EN && (Q == MAX);

endmodule

// File: rtl/mmss_stopwatch.sv
// Start/stop/clear mm:ss stopwatch counting one-second TICK pulses in BCD.
// Latency: digits and ROLLOVER one clock after TICK; START edge seen 2 clocks late when synchronized.
// Backpressure: none; ticks outside RUN are dropped, never queued.
module mmss_stopwatch
    import mmss_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5,
    parameter bit SYNC_START   = 1'b1
) (
    input  logic               CLOCK,
    input  logic               RESET,
    mmss_stopwatch_if.slave    bus
);

    logic   sync1, sync2, start_s, start_prev, armed, pipe_low, start_edge;
    state_t state_q, state_d;
    logic   running, count_en;
    logic   c_so, c_st, c_mo, wrap;
    logic   rollover_q;

    // A button held through reset must be released once before it can start
    // the count, so the edge detector only arms after it has seen START low.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            start_prev <= 1'b0;
            armed      <= 1'b0;
        end else begin
            sync1      <= bus.START;
            sync2      <= sync1;
            start_prev <= start_s;
            if (pipe_low) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_s    = SYNC_START ? sync2 : bus.START;
    assign pipe_low   = SYNC_START ? ~(bus.START | sync1 | sync2) : ~bus.START;
    assign start_edge = armed & start_s & ~start_prev;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.CLR_TIME) begin
            state_d = ST_IDLE;
        end else if (start_edge) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Counting keys off the pre-edge state: the tick that pauses is counted,
    // the tick that resumes or starts is not.
    always_comb begin
        running  = (state_q == ST_RUN);
        count_en = bus.TICK && (state_q == ST_RUN) && !bus.CLR_TIME;
    end

    bcd_digit #(.MAX(BCD_MAX_ONES)) u_sec_ones (
        .CLOCK(CLOCK), .RESET(RESET), .CLR(bus.CLR_TIME),
        .EN(count_en), .Q(bus.SEC_ONES), .CARRY(c_so)
    );

    bcd_digit #(.MAX(BCD_MAX_TENS)) u_sec_tens (
        .CLOCK(CLOCK), .RESET(RESET), .CLR(bus.CLR_TIME),
        .EN(c_so), .Q(bus.SEC_TENS), .CARRY(c_st)
    );

    bcd_digit #(.MAX(BCD_MAX_ONES)) u_min_ones (
        .CLOCK(CLOCK), .RESET(RESET), .CLR(bus.CLR_TIME),
        .EN(c_st), .Q(bus.MIN_ONES), .CARRY(c_mo)
    );

    bcd_digit #(.MAX(4'(MIN_TENS_MAX))) u_min_tens (
        .CLOCK(CLOCK), .RESET(RESET), .CLR(bus.CLR_TIME),
        .EN(c_mo), .Q(bus.MIN_TENS), .CARRY(wrap)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rollover_q <= 1'b0;
        end else begin
            rollover_q <= wrap;
        end
    end

    assign bus.RUNNING  = running;
    assign bus.ROLLOVER = rollover_q;

endmodule
